// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller: state encoding
// and the default operand width.
package serial_subtractor_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // 2'd3 is unused; the FSM recovers from it to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor_using_demux.sv
// 1-bit full subtractor built from a one-hot decode (1:4 demux) of the {a, b} pair,
// with bin choosing which demux outputs form diff and bout.
module full_subtractor_using_demux (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic [3:0] sel_hot;

  always_comb begin
    sel_hot = 4'b0000;
    sel_hot[{a, b}] = 1'b1;
  end

  // a==b passes bin straight through; a=0,b=1 always borrows; a=1,b=0 never does.
  assign diff = bin ? (sel_hot[0] | sel_hot[3]) : (sel_hot[1] | sel_hot[2]);
  assign bout = bin ? (sel_hot[0] | sel_hot[1] | sel_hot[3]) : sel_hot[1];

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor slice stepped LSB first,
// borrow carried in a register, operands and result on valid/ready handshakes.
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CNT_W-1:0] idx;
  logic             borrow;
  logic             slice_diff;
  logic             slice_bout;

  full_subtractor_using_demux u_slice (
    .a    (a_r[idx]),
    .b    (b_r[idx]),
    .bin  (borrow),
    .diff (slice_diff),
    .bout (slice_bout)
  );

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state == ST_RUN);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (abort) begin
      // Abort wins over both handshakes: nothing is captured, nothing delivered.
      state <= ST_IDLE;
      idx   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_r    <= a;
            b_r    <= b;
            borrow <= bin;
            diff   <= '0;
            idx    <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          diff[idx] <= slice_diff;
          borrow    <= slice_bout;
          if (idx == LAST_IDX) begin
            bout  <= slice_bout;
            state <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Bit-serial N-bit subtractor controller. It sequences one 1-bit full-subtractor bit-slice across a WIDTH-bit operand pair, LSB first, one bit per clock, with a registered borrow chain between cycles. Operands and results move over valid/ready handshakes. The block sits between an operand source (register file or sequencer) and a result consumer in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.
- CNT_W, $clog2(WIDTH) (minimum 1), bit-index counter width; derived locally, never overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous abort; returns the block to IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  initial borrow-in for bit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  out  1  final borrow-out; 1 when a < b + bin (unsigned).
- busy  out  1  high in RUN.

Behaviour:
- States: IDLE, RUN, DONE. All state and outputs are registered; in_ready, busy and out_valid are decoded from state.
- Reset (rst_n low, asynchronous):
  - state=IDLE, so in_ready=1, busy=0, out_valid=0.
  - diff=0, bout=0, bit index=0, borrow reg=0, operand regs=0.
- IDLE:
  - On in_valid&&in_ready at an edge: capture a, b, bin into operand regs, clear diff, idx=0, borrow=bin, go to RUN.
  - in_valid without a transfer has no effect.
- RUN, each cycle:
  - The bit-slice sees a_r[idx], b_r[idx], borrow.
  - At the edge: diff[idx] takes the slice difference, borrow takes the slice borrow-out, idx increments.
  - When idx==WIDTH-1: the final borrow is written to bout and the state goes to DONE; idx does not wrap past WIDTH-1.
- Latency: operands captured at edge T, out_valid high after edge T+WIDTH. WIDTH=1 means exactly one RUN cycle.
- DONE:
  - out_valid=1; diff and bout are held stable until out_valid&&out_ready.
  - On that transfer: go to IDLE. No same-cycle reaccept, so in_ready rises the cycle after.
  - Throughput is one operation per WIDTH+2 cycles with out_ready held high.
- in_ready=0 in RUN and DONE. in_valid is ignored there, with no queuing.
- abort (any state, synchronous):
  - Next state IDLE, out_valid=0, diff=0, bout=0, idx=0.
  - abort has priority over the handshake. An in_valid transfer in the same cycle is dropped, and a DONE result is discarded even if out_ready is high.
- Reset mid-RUN or mid-DONE: immediate return to the reset values above. No partial result is ever presented.
- Arithmetic: unsigned. diff equals (a - b - bin) mod 2^WIDTH. Signed interpretation is the consumer's concern.

Decomposition:
- Shared header/package holds:
  - State encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2. Encoding 2'd3 is illegal and recovers to IDLE.
  - Default WIDTH constant.
- One sub-module instance: the team's existing 1-bit demux-based full-subtractor cell, full_subtractor_using_demux (inputs a, b, bin; outputs diff, bout), instantiated once as the bit-slice.
- The FSM, counter, borrow reg and shift/index logic live in serial_subtractor_ctrl.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, out_ready=1 -> out_valid exactly 8 edges after capture, diff=0x1E, bout=0, in_ready back high 2 cycles later.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0.
- Backpressure: a=0x80, b=0x01, with out_ready low for 5 cycles after out_valid -> diff=0x7F and bout=0 held stable all 5 cycles, in_ready=0 throughout, single transfer on release. A second in_valid pulse during RUN is ignored.
- abort asserted while idx=3 -> next cycle state IDLE, in_ready=1, out_valid never asserted, diff=0. A following op a=0x10, b=0x01 gives diff=0x0F.
- rst_n dropped asynchronously mid-RUN (between edges) -> outputs go to reset values immediately. After release, a=0x03, b=0x05 gives diff=0xFE, bout=1.
- WIDTH=1 build: a=0, b=1, bin=0 -> out_valid 1 edge after capture, diff=1, bout=1.
